// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS pipeline control blocks: forwarding selects,
// hazard controller FSM states and the default drain length.
package mips_pkg;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_EXE = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2,
      ST_STEP   = 2'd3
   } hz_state_t;

   localparam int DEFAULT_DRAIN_CYCLES = 3;

endpackage

// File: rtl/forwarding_exe.sv
// Operand forwarding select for one EXE source register. The younger result
// in EX/MEM wins over MEM/WB; register 0 is hard-wired and never forwarded.
module forwarding_exe
   import mips_pkg::*;
(
   input  logic [4:0] ex_src,
   input  logic [4:0] mem_dest,
   input  logic       mem_reg_write,
   input  logic [4:0] wb_dest,
   input  logic       wb_reg_write,
   output logic [1:0] sel
);

   // pick the most recent in-flight producer of ex_src
   always_comb begin
      sel = FWD_REG;
      if (mem_reg_write && (mem_dest != 5'd0) && (mem_dest == ex_src))
         sel = FWD_EXE;
      else if (wb_reg_write && (wb_dest != 5'd0) && (wb_dest == ex_src))
         sel = FWD_MEM;
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS core: forwarding
// selects, load-use stalls, taken-branch flushes, a debug halt/step/drain
// FSM and saturating performance counters.
module hazard_ctrl
   import mips_pkg::*;
#(
   parameter int CNT_W        = 32,
   parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic [4:0]       ex_rs,
   input  logic [4:0]       ex_rt,
   input  logic [4:0]       ex_dest,
   input  logic             ex_mem_read,
   input  logic [4:0]       mem_dest,
   input  logic             mem_reg_write,
   input  logic [4:0]       wb_dest,
   input  logic             wb_reg_write,
   input  logic             branch_taken,
   input  logic             halt_req,
   input  logic             step_req,
   input  logic             resume_req,
   output logic [1:0]       for_a,
   output logic [1:0]       for_b,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             id_ex_bubble,
   output logic             flush_if_id,
   output logic             flush_id_ex,
   output logic             flush_ex_mem,
   output logic             halted,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

   hz_state_t          state;
   logic [DRAIN_W-1:0] drain_cnt;
   logic               halted_r;
   logic [1:0]         sel_a;
   logic [1:0]         sel_b;
   logic               lu;
   logic               stall;
   logic               hold;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   forwarding_exe u_fwd_a (
      .ex_src        (ex_rs),
      .mem_dest      (mem_dest),
      .mem_reg_write (mem_reg_write),
      .wb_dest       (wb_dest),
      .wb_reg_write  (wb_reg_write),
      .sel           (sel_a)
   );

   forwarding_exe u_fwd_b (
      .ex_src        (ex_rt),
      .mem_dest      (mem_dest),
      .mem_reg_write (mem_reg_write),
      .wb_dest       (wb_dest),
      .wb_reg_write  (wb_reg_write),
      .sel           (sel_b)
   );

   // load-use detection and the resulting stall / freeze qualifiers
   always_comb begin
      lu    = ex_mem_read && (ex_dest != 5'd0) &&
              ((ex_dest == id_rs) || (id_uses_rt && (ex_dest == id_rt)));
      // a taken branch discards the dependent instruction, so no stall
      stall = lu && !branch_taken && ((state == ST_RUN) || (state == ST_STEP));
      hold  = (state == ST_DRAIN) || (state == ST_HALTED);
   end

   // pipeline enables, bubbles and flushes; reset parks the pipe in a safe state
   always_comb begin
      for_a        = sel_a;
      for_b        = sel_b;
      pc_write     = branch_taken || !(hold || stall);
      if_id_write  = !(hold || stall);
      id_ex_bubble = hold || stall;
      flush_if_id  = branch_taken;
      flush_id_ex  = branch_taken;
      flush_ex_mem = branch_taken;
      halted       = halted_r;
      if (reset) begin
         for_a        = FWD_REG;
         for_b        = FWD_REG;
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_bubble = 1'b1;
         flush_if_id  = 1'b1;
         flush_id_ex  = 1'b1;
         flush_ex_mem = 1'b1;
         halted       = 1'b0;
      end
   end

   // debug sequencing FSM: RUN -> DRAIN -> HALTED, with single-step via STEP
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ST_RUN;
         drain_cnt <= '0;
         halted_r  <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               if (halt_req) begin
                  state     <= ST_DRAIN;
                  drain_cnt <= DRAIN_LOAD;
               end
            end
            ST_DRAIN: begin
               if (drain_cnt == '0) begin
                  state    <= ST_HALTED;
                  halted_r <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt - 1'b1;
               end
            end
            ST_HALTED: begin
               if (resume_req) begin
                  state    <= ST_RUN;
                  halted_r <= 1'b0;
               end else if (step_req) begin
                  state    <= ST_STEP;
                  halted_r <= 1'b0;
               end
            end
            ST_STEP: begin
               // a load-use stall delays the release by one cycle
               if (!stall) begin
                  state     <= ST_DRAIN;
                  drain_cnt <= DRAIN_LOAD;
               end
            end
            default: begin
               state    <= ST_RUN;
               halted_r <= 1'b0;
            end
         endcase
      end
   end

   // saturating performance counters, updated the cycle after each event
   always_ff @(posedge clock) begin
      if (reset) begin
         cycle_count <= '0;
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (state != ST_HALTED) cycle_count <= sat_inc(cycle_count);
         if (stall)              stall_count <= sat_inc(stall_count);
         if (branch_taken)       flush_count <= sat_inc(flush_count);
      end
   end

endmodule
